mixer_input_conditioner: RTL and testbench
==========================================

// Module: mixer_input_conditioner
// PURPOSE
//  Upstream front end of the liquid mixer FSM; sole source of its x0/x1/x2/x10 inputs.
//  Synchronises and debounces the raw start button, low/high level sensors and e-stop.
//  Start and level sensors become one-cycle rising-edge pulses.
//  E-stop becomes a fast, latched emergency level that is released only by an explicit clear.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable synchronised cycles needed to accept a new level (>=2)
//  CNT_W  $clog2(DEBOUNCE_CYCLES)  derived width of each channel's stability counter; not overridden
// PORTS
//  clk          in   1  single system clock, all logic on posedge
//  rst          in   1  asynchronous, active-high reset
//  start_raw    in   1  raw start pushbutton, asynchronous to clk
//  low_raw      in   1  raw low-level float switch, asynchronous
//  high_raw     in   1  raw high-level float switch, asynchronous
//  estop_raw    in   1  raw emergency-stop contact, asynchronous, 1 = stop requested
//  estop_clear  in   1  synchronous operator acknowledge for releasing the emergency
//  x0           out  1  start pulse to mixer FSM, one cycle
//  x1           out  1  low-level pulse, one cycle
//  x2           out  1  high-level pulse, one cycle
//  x10          out  1  emergency level, latched
//  db_level     out  4  debounced levels {estop,high,low,start}, for status/debug
// BEHAVIOUR
//  Reset: every flop clears, so all outputs are 0 and all counters are 0.
//   Reset mid-debounce discards partial counts; no pulse is emitted on reset release.
//  Per channel (start/low/high/estop), with N = DEBOUNCE_CYCLES:
//   - 2-FF synchroniser s1 -> s2.
//   - Debounce rule, evaluated each edge:
//       if s2 == db: cnt <= 0
//       else if cnt == N-1: db <= s2; cnt <= 0
//       else: cnt <= cnt + 1
//   - rise <= (s2 & ~db & cnt == N-1), registered, so it is high for exactly one cycle.
//  Latency: raw held high from before edge 0 makes db flip and rise high in the cycle after edge N+1.
//   Total: N+2 edges from the raw change.
//  Glitch filtering:
//   - Any raw excursion shorter than N synchronised cycles produces no db change and no pulse.
//   - A bounce back mid-count restarts the count from 0.
//  Falling edges update db with the same N-cycle rule but never produce a pulse.
//  Holding an input high yields one pulse only; re-triggering requires a debounced low first.
//  x1 = rise_low and x2 = rise_high, unconditionally.
//  x0 = rise_start & ~x10: start is suppressed while the emergency is active (dropped, not queued).
//  x10 (fast path, no debounce):
//   - Set at the edge after estop s2 == 1, i.e. high in the cycle after edge 2.
//   - Cleared at an edge where estop_clear == 1 AND db_estop == 0.
//   - estop_clear is ignored while the debounced e-stop is still asserted.
//   - If set and clear conditions coincide, set wins.
//   - A sub-N e-stop glitch still latches x10.
//  x0/x1/x2 are never high in the same cycle as a rst assertion.
//   Any channels that complete in the same cycle may pulse together.
// STRUCTURE
//  Shared package liquid_mixer_pkg:
//   - localparams CH_START = 0, CH_LOW = 1, CH_HIGH = 2, CH_ESTOP = 3, NUM_CH = 4.
//   - Default DEBOUNCE_CYCLES value.
//  Sub-module debounce_channel #(DEBOUNCE_CYCLES), instantiated NUM_CH times in a generate loop.
//   - Inputs: clk, rst, raw. Outputs: sync (s2), level (db), rise.
//  Top level holds only the x10 latch, start suppression and output wiring.
//  No FSM beyond the per-channel counter and the 1-bit emergency latch.
// TESTING (N = 4 unless noted)
//  1. Reset values: rst pulsed with all raw inputs 1
//     -> all outputs 0 during reset; x10 is 1 at the 3rd edge after release; no x0/x1/x2 pulse.
//  2. Clean start: start_raw 0 -> 1 before edge 0, held 20 cycles
//     -> x0 high in exactly the cycle after edge 5, once; db_level[0] = 1.
//  3. Bounce: start_raw high 3 cycles, low 1, high 10
//     -> no pulse from the first burst; one x0 pulse N+2 edges after the final rise.
//  4. Level sensors: low_raw rises, 8 cycles later high_raw rises
//     -> x1 pulse, then x2 pulse 8 cycles later; falling edges produce no pulses.
//  5. Emergency: estop_raw 1-cycle glitch -> x10 latches.
//     - Press start -> no x0.
//     - estop_clear while estop_raw held high -> x10 stays 1.
//     - Release estop_raw, wait N+2, then estop_clear -> x10 is 0 the next cycle.
//  6. Reset mid-debounce: start_raw rises, rst asserted at edge 3, start_raw held
//     -> no x0 before release; x0 pulses N+2 edges after rst drops.

Source files
------------

// File: rtl/liquid_mixer_pkg.sv
// Shared constants for the liquid mixer front end.
// Channel indices into the raw/debounced input vectors.
package liquid_mixer_pkg;
   localparam int CH_START = 0;
   localparam int CH_LOW   = 1;
   localparam int CH_HIGH  = 2;
   localparam int CH_ESTOP = 3;
   localparam int NUM_CH   = 4;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
endpackage

// File: rtl/mixer_input_conditioner_debounce_channel.sv
// One input channel: 2-FF synchroniser, counting debouncer
// and registered rising-edge pulse.
module debounce_channel
   import liquid_mixer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic sync,
   output logic level,
   output logic rise
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic [CNT_W-1:0] cnt;
   logic             at_max;

   assign at_max = (cnt == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         sync  <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         s1   <= raw;
         sync <= s1;
         rise <= sync & ~level & at_max;
         // any bounce back to the accepted level restarts the count
         if (sync == level) begin
            cnt <= '0;
         end else if (at_max) begin
            level <= sync;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/mixer_input_conditioner.sv
// Conditions raw mixer inputs into the x0/x1/x2 pulses and
// the latched x10 emergency level for the mixer FSM.
module mixer_input_conditioner
   import liquid_mixer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_raw,
   input  logic              low_raw,
   input  logic              high_raw,
   input  logic              estop_raw,
   input  logic              estop_clear,
   output logic              x0,
   output logic              x1,
   output logic              x2,
   output logic              x10,
   output logic [NUM_CH-1:0] db_level
);
   logic [NUM_CH-1:0] raw;
   logic [NUM_CH-1:0] sync;
   logic [NUM_CH-1:0] level;
   logic [NUM_CH-1:0] rise;
   logic              unused_bits;

   assign raw[CH_START] = start_raw;
   assign raw[CH_LOW]   = low_raw;
   assign raw[CH_HIGH]  = high_raw;
   assign raw[CH_ESTOP] = estop_raw;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw[g]),
         .sync (sync[g]),
         .level(level[g]),
         .rise (rise[g])
      );
   end

   // e-stop latches off the synchronised level, not the debounced one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x10 <= 1'b0;
      end else if (sync[CH_ESTOP]) begin
         x10 <= 1'b1;
      end else if (estop_clear && !level[CH_ESTOP]) begin
         x10 <= 1'b0;
      end
   end

   assign x0       = rise[CH_START] & ~x10;
   assign x1       = rise[CH_LOW];
   assign x2       = rise[CH_HIGH];
   assign db_level = level;

   assign unused_bits = ^{sync[CH_HIGH:CH_START], rise[CH_ESTOP]};
endmodule

// File: tb/tb_mixer_input_conditioner.sv
// Directed bench for mixer_input_conditioner with N = 4.
// Per-cycle vector table plus a hand-written hold sequence.
module tb_mixer_input_conditioner;
   typedef struct {
      logic       rst;
      logic       start;
      logic       low;
      logic       high;
      logic       estop;
      logic       clear;
      logic       x0;
      logic       x1;
      logic       x2;
      logic       x10;
      logic [3:0] db;
      string      tag;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_raw;
   logic       low_raw;
   logic       high_raw;
   logic       estop_raw;
   logic       estop_clear;
   logic       x0;
   logic       x1;
   logic       x2;
   logic       x10;
   logic [3:0] db_level;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];

   mixer_input_conditioner #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_raw  (start_raw),
      .low_raw    (low_raw),
      .high_raw   (high_raw),
      .estop_raw  (estop_raw),
      .estop_clear(estop_clear),
      .x0         (x0),
      .x1         (x1),
      .x2         (x2),
      .x10        (x10),
      .db_level   (db_level)
   );

   always #5 clk = ~clk;

   function automatic void add(
      input logic r, input logic s, input logic l,
      input logic h, input logic e, input logic c,
      input logic e0, input logic e1, input logic e2,
      input logic e10, input logic [3:0] edb,
      input string t);
      vec_t v;
      v.rst = r;   v.start = s; v.low = l;
      v.high = h;  v.estop = e; v.clear = c;
      v.x0 = e0;   v.x1 = e1;   v.x2 = e2;
      v.x10 = e10; v.db = edb;  v.tag = t;
      tbl.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string t, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", t, got, want);
      end
   endtask

   initial begin
      int pulses;
      int first;
      logic [7:0] got;
      logic [7:0] want;

      // reset with all raw inputs high, then re-reset to quiet
      for (int i = 0; i < 10; i++)
         add((i < 2) || (i == 5) || (i == 6),
             i < 5, i < 5, i < 5, i < 5, 1'b0,
             1'b0, 1'b0, 1'b0, i == 4, 4'b0000, "reset");
      // clean start held 20 cycles, then released 8
      for (int i = 0; i < 28; i++)
         add(1'b0, i < 20, 1'b0, 1'b0, 1'b0, 1'b0,
             i == 5, 1'b0, 1'b0, 1'b0,
             {3'b000, (i >= 5) && (i <= 24)}, "clean");
      // bounce: high 3, low 1, high 10, then low
      for (int i = 0; i < 22; i++)
         add(1'b0, (i < 3) || ((i >= 4) && (i <= 13)),
             1'b0, 1'b0, 1'b0, 1'b0,
             i == 9, 1'b0, 1'b0, 1'b0,
             {3'b000, (i >= 9) && (i <= 18)}, "bounce");
      // level sensors, falls produce no pulses
      for (int i = 0; i < 24; i++)
         add(1'b0, 1'b0, i < 16, (i >= 8) && (i < 16),
             1'b0, 1'b0,
             1'b0, i == 5, i == 13, 1'b0,
             {1'b0, (i >= 13) && (i <= 20),
              (i >= 5) && (i <= 20), 1'b0}, "levels");
      // e-stop glitch latches, start is dropped
      for (int i = 0; i < 18; i++)
         add(1'b0, (i >= 3) && (i <= 10), 1'b0, 1'b0,
             i == 0, 1'b0,
             1'b0, 1'b0, 1'b0, i >= 2,
             {3'b000, (i >= 8) && (i <= 15)}, "estop_glitch");
      // clear ignored while debounced e-stop still high
      for (int i = 0; i < 22; i++)
         add(1'b0, 1'b0, 1'b0, 1'b0, i < 12,
             (i == 8) || (i == 15) || (i == 19),
             1'b0, 1'b0, 1'b0, i < 19,
             {(i >= 5) && (i <= 16), 3'b000}, "estop_clear");
      // set wins over a coincident clear
      for (int i = 0; i < 7; i++)
         add(1'b0, 1'b0, 1'b0, 1'b0, i == 0,
             (i == 2) || (i == 5),
             1'b0, 1'b0, 1'b0, (i >= 2) && (i < 5),
             4'b0000, "set_wins");
      // reset mid-debounce discards the partial count
      for (int i = 0; i < 21; i++)
         add((i == 3) || (i == 4), i < 14, 1'b0, 1'b0,
             1'b0, 1'b0,
             i == 10, 1'b0, 1'b0, 1'b0,
             {3'b000, (i >= 10) && (i <= 18)}, "rst_mid");

      foreach (tbl[k]) begin
         rst         = tbl[k].rst;
         start_raw   = tbl[k].start;
         low_raw     = tbl[k].low;
         high_raw    = tbl[k].high;
         estop_raw   = tbl[k].estop;
         estop_clear = tbl[k].clear;
         step();
         got  = {x0, x1, x2, x10, db_level};
         want = {tbl[k].x0, tbl[k].x1, tbl[k].x2,
                 tbl[k].x10, tbl[k].db};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] got x0x1x2x10_db=%b want %b",
                     tbl[k].tag, k, got, want);
         end
      end

      // long hold: exactly one pulse at the expected latency
      pulses = 0;
      first  = -1;
      start_raw = 1'b1;
      for (int c = 0; c < 30; c++) begin
         step();
         if (x0 === 1'b1) begin
            pulses++;
            if (first < 0) first = c;
         end
      end
      check("hold_pulses", pulses, 1);
      check("hold_latency", first, 5);
      check("hold_db", int'(db_level), 1);
      start_raw = 1'b0;
      for (int c = 0; c < 8; c++) step();
      check("hold_release_db", int'(db_level), 0);
      check("hold_x10", int'(x10), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
